uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
- REQ-001 SHALL have parameter `OSR`, default 16, meaning clk cycles per bit (oversampling ratio); must be an even value ≥ 4.
- REQ-002 SHALL have port `clk`, input, width 1: single clock, OSR × baud (153.6 kHz for 9600 baud); all flops on its rising edge.
- REQ-003 SHALL have port `rstn`, input, width 1: reset, asynchronous, active-low.
- REQ-004 SHALL have port `rxd`, input, width 1: serial line, asynchronous to clk; idle high.
- REQ-005 SHALL have port `rdy_rx`, input, width 1: consumer ready to take the received byte.
- REQ-006 SHALL have port `d_rx`, output, width 8: received byte.
- REQ-007 SHALL have port `vld_rx`, output, width 1: d_rx holds a valid, unconsumed byte.
- REQ-008 SHALL have port `frm_err`, output, width 1: one-cycle pulse when the stop bit samples 0 (or parity fails when PARITY_EN is defined).
- REQ-009 SHALL have port `ovr_err`, output, width 1: one-cycle pulse when a good frame completes while the previous byte is unconsumed.

Function
- REQ-010 SHALL accept frame format: start bit 0, 8 data bits LSB first, optional parity bit, stop bit 1; this is the frame produced by the team's UART TX stage.
- REQ-011 SHALL pass rxd through a 2-flop synchronizer (both flops reset to 1); all logic uses the synchronized signal `rxs`.
- REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY (present only with PARITY_EN), STOP.
- REQ-013 SHALL, in IDLE, on rxs = 0: go to START and clear the bit-cycle counter.
- REQ-014 SHALL, in START, sample rxs after OSR/2 cycles: if 0, go to DATA and restart the counter; if 1, treat as a glitch and return to IDLE with no error.
- REQ-015 SHALL, in DATA, sample rxs every OSR cycles (mid-bit) and shift it into bit 7 of the shift register, shifting right; after the 8th sample go to PARITY or STOP.
- REQ-016 SHALL, in STOP, sample rxs after OSR cycles, then return to IDLE on the next cycle; with OSR = 16 this allows back-to-back frames with a start bit 8 cycles early.
- REQ-017 SHALL, on a good stop: on the next clk edge set d_rx to the shift register and vld_rx to 1.
- REQ-018 SHALL, on a bad stop: pulse frm_err for one cycle; d_rx and vld_rx are unchanged.
- REQ-019 SHALL complete the handshake (vld_rx & rdy_rx) at a clock edge; vld_rx falls on that edge unless a good frame completes on the same edge, in which case d_rx takes the new byte and vld_rx stays 1 with no ovr_err.
- REQ-020 SHALL, on a good frame while vld_rx = 1 and rdy_rx = 0: pulse ovr_err; d_rx keeps the old byte and the new byte is dropped.
- REQ-021 SHALL hold d_rx stable while vld_rx = 1.
- REQ-022 SHALL make rdy_rx ignored while vld_rx = 0.
- REQ-023 SHALL place the stop sample at 8 + 16×9 = 152 cycles after the first rxs = 0 cycle (OSR = 16, no parity); vld_rx rises 1 cycle later.

Reset
- REQ-024 SHALL, on rstn low, immediately force: state IDLE, counters 0, shift register 0, d_rx = 0x00, vld_rx = 0, frm_err = 0, ovr_err = 0, synchronizer = 1.
- REQ-025 SHALL abandon any partial frame on reset mid-frame, with no output; reception resumes at the next falling edge after rstn rises.

Configuration
- REQ-026 SHALL use macro `UART_RX_PARITY_EN` to control parity.
- REQ-027 SHALL, when `UART_RX_PARITY_EN` is defined: add the PARITY state, sampled OSR cycles after the last data bit, even parity (XOR of data and parity = 0); mismatch pulses frm_err at the stop sample and the byte is discarded; stop sample moves to 168 cycles.
- REQ-028 SHALL, when `UART_RX_PARITY_EN` is undefined: omit the PARITY state and logic; frame is 10 bits.

Verification
- REQ-029 SHALL cover: frame 0xA5, rdy_rx = 1 → d_rx = 0xA5, vld_rx high for exactly 1 cycle, 153 cycles after rxs falls; no error pulses.
- REQ-030 SHALL cover: 0x3C then 0xC3 back-to-back, rdy_rx = 0 → d_rx = 0x3C held, vld_rx = 1, ovr_err pulses once at the second stop.
- REQ-031 SHALL cover: 0x55 with stop bit forced 0 → frm_err 1-cycle pulse, vld_rx stays 0, d_rx = 0x00; next frame 0x0F is received correctly.
- REQ-032 SHALL cover: rxd low pulse of 4 cycles while idle → returns to IDLE, no vld_rx, no frm_err.
- REQ-033 SHALL cover: rstn low during data bit 4 of 0xFF → all outputs 0 immediately; following frame 0x81 is received as 0x81.
- REQ-034 SHALL cover, when `UART_RX_PARITY_EN` is defined: 0x07 with parity 1 → received OK; same frame with parity 0 → frm_err, no vld_rx.

Source files
------------

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// UART receiver: start bit, 8 data bits LSB first, stop bit; OSR clocks per bit, mid-bit sampling.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data and stop bits.
module uart_rx #(
  parameter int OSR = 16  // even, >= 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  input  logic       rdy_rx,
  output logic [7:0] d_rx,
  output logic       vld_rx,
  output logic       frm_err,
  output logic       ovr_err
);

  localparam int CW = $clog2(OSR);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic          r_sync1;
  logic          r_rxs;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          w_half_bit;
  logic          w_full_bit;
  logic          w_stop_ok;

  // NOTE: both synchronizer flops reset to 1 so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_rxs   <= r_sync1;
    end
  end

  assign w_half_bit = (r_cnt == CW'(OSR/2 - 1));
  assign w_full_bit = (r_cnt == CW'(OSR - 1));

`ifdef UART_RX_PARITY_EN
  logic r_par_err;

  assign w_stop_ok = r_rxs && !r_par_err;
`else
  assign w_stop_ok = r_rxs;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      d_rx      <= '0;
      vld_rx    <= 1'b0;
      frm_err   <= 1'b0;
      ovr_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_err <= 1'b0;
`endif
    end else begin
      // NOTE: pulse outputs default low each cycle; a later assignment in this block wins.
      frm_err <= 1'b0;
      ovr_err <= 1'b0;
      if (vld_rx && rdy_rx)
        vld_rx <= 1'b0;

      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (!r_rxs)
            r_state <= START;
        end

        START: begin
          if (w_half_bit) begin
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_state   <= r_rxs ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        DATA: begin
          if (w_full_bit) begin
            r_cnt     <= '0;
            r_shift   <= {r_rxs, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (w_full_bit) begin
            r_cnt     <= '0;
            r_par_err <= ^{r_rxs, r_shift};
            r_state   <= STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`endif

        STOP: begin
          if (w_full_bit) begin
            r_cnt   <= '0;
            r_state <= IDLE;
            if (!w_stop_ok) begin
              frm_err <= 1'b1;
            end else if (vld_rx && !rdy_rx) begin
              ovr_err <= 1'b1;
            end else begin
              // A handshake on this same edge is overridden: the new byte replaces the old one.
              d_rx   <= r_shift;
              vld_rx <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Self-checking bench for uart_rx: directed frames plus random bytes checked against a
// frame-level model of what the consumer should see. Honors UART_RX_PARITY_EN.
module tb_uart_rx;

  localparam int OSR = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  // 2 synchronizer edges, stop sample OSR/2 + OSR*(9+NPAR) after rxs falls, output 1 edge later
  localparam int LATENCY = 2 + OSR/2 + OSR*(9 + NPAR) + 1;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rxd = 1'b1;
  logic       rdy_rx = 1'b0;
  logic [7:0] d_rx;
  logic       vld_rx;
  logic       frm_err;
  logic       ovr_err;

  int checks = 0;
  int failures = 0;

  int   cyc = 0;
  int   frm_cnt = 0;
  int   ovr_cnt = 0;
  int   vld_hi = 0;
  int   rise_cyc = -1;
  int   fall_cyc = 0;
  logic prev_vld = 1'b0;

  logic       exp_vld;
  logic [7:0] exp_d;

  uart_rx #(.OSR(OSR)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .rxd     (rxd),
    .rdy_rx  (rdy_rx),
    .d_rx    (d_rx),
    .vld_rx  (vld_rx),
    .frm_err (frm_err),
    .ovr_err (ovr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frm_err) frm_cnt <= frm_cnt + 1;
    if (ovr_err) ovr_cnt <= ovr_cnt + 1;
    if (vld_rx)  vld_hi  <= vld_hi + 1;
    if (vld_rx && !prev_vld) rise_cyc <= cyc;
    prev_vld <= vld_rx;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (OSR) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_b, input logic par_b);
    fall_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_b);
`endif
    send_bit(stop_b);
    rxd = 1'b1;
  endtask

  function automatic logic frame_good(input logic [7:0] data, input logic stop_b, input logic par_b);
`ifdef UART_RX_PARITY_EN
    return stop_b && ((^data ^ par_b) == 1'b0);
`else
    return stop_b;
`endif
  endfunction

  // Sends one frame and checks the consumer-visible result against the frame-level model.
  task automatic run_frame(input string tag, input logic [7:0] data, input logic stop_b,
                           input logic par_b, input int gap);
    int   f0, o0, v0;
    logic good;
    int   exp_f, exp_o, exp_v;
    if (rdy_rx && exp_vld) begin
      @(negedge clk);
      exp_vld = 1'b0;
    end
    f0 = frm_cnt;
    o0 = ovr_cnt;
    v0 = vld_hi;
    good = frame_good(data, stop_b, par_b);
    send_frame(data, stop_b, par_b);
    idle(gap);
    exp_f = good ? 0 : 1;
    exp_o = 0;
    exp_v = 0;
    if (good) begin
      if (exp_vld && !rdy_rx) begin
        exp_o = 1;
      end else begin
        exp_d   = data;
        exp_vld = !rdy_rx;
        exp_v   = 1;
      end
    end
    check($sformatf("%s_vld", tag), vld_rx, exp_vld);
    check($sformatf("%s_d", tag), d_rx, exp_d);
    check($sformatf("%s_frm", tag), frm_cnt - f0, exp_f);
    check($sformatf("%s_ovr", tag), ovr_cnt - o0, exp_o);
    if (rdy_rx) check($sformatf("%s_vldcyc", tag), vld_hi - v0, exp_v);
  endtask

  initial begin
    logic [7:0] data;
    logic       stop_b;
    logic       par_b;
    int         f0, v0;

    exp_vld = 1'b0;
    exp_d   = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_vld", vld_rx, 0);
    check("rst_d", d_rx, 0);
    check("rst_frm", frm_err, 0);
    check("rst_ovr", ovr_err, 0);
    rstn = 1'b1;
    idle(10);

    // Bad stop bit, then a clean frame
    rdy_rx = 1'b0;
    run_frame("bad_stop_55", 8'h55, 1'b0, ^8'h55, 24);
    run_frame("after_err_0f", 8'h0F, 1'b1, ^8'h0F, 24);

    // Consumer ready: one-cycle valid at the expected latency
    rdy_rx = 1'b1;
    run_frame("a5", 8'hA5, 1'b1, ^8'hA5, 24);
    check("a5_latency", rise_cyc - fall_cyc, LATENCY);

    // Back-to-back with consumer stalled: overrun on the second
    rdy_rx = 1'b0;
    run_frame("b2b_3c", 8'h3C, 1'b1, ^8'h3C, 0);
    run_frame("b2b_c3", 8'hC3, 1'b1, ^8'hC3, 24);

    // Reset mid-frame during data bit 4 of 0xFF, with a byte still pending
    rxd = 1'b0;
    repeat (OSR) @(negedge clk);
    rxd = 1'b1;
    repeat (4 * OSR + OSR/2) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("mid_rst_vld", vld_rx, 0);
    check("mid_rst_d", d_rx, 0);
    check("mid_rst_frm", frm_err, 0);
    check("mid_rst_ovr", ovr_err, 0);
    exp_vld = 1'b0;
    exp_d   = 8'h00;
    repeat (3 * OSR) @(negedge clk);
    rstn = 1'b1;
    idle(10);
    run_frame("post_rst_81", 8'h81, 1'b1, ^8'h81, 24);
    rdy_rx = 1'b1;
    repeat (2) @(negedge clk);
    exp_vld = 1'b0;
    check("consume_81", vld_rx, exp_vld);

    // Short low glitch while idle
    f0 = frm_cnt;
    v0 = vld_hi;
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    idle(3 * OSR);
    check("glitch_vld", vld_hi - v0, 0);
    check("glitch_frm", frm_cnt - f0, 0);
    run_frame("after_glitch", 8'h6E, 1'b1, ^8'h6E, 24);

    // Random frames, random consumer readiness, occasional bad stop / parity
    for (int k = 0; k < 10; k++) begin
      data   = 8'($urandom);
      stop_b = ($urandom_range(0, 3) != 0);
      par_b  = (^data) ^ ($urandom_range(0, 4) == 0);
      rdy_rx = 1'($urandom_range(0, 1));
      repeat (2) @(negedge clk);
      run_frame($sformatf("rand%0d", k), data, stop_b, par_b, 24);
    end

`ifdef UART_RX_PARITY_EN
    rdy_rx = 1'b1;
    repeat (2) @(negedge clk);
    run_frame("par_ok_07", 8'h07, 1'b1, 1'b1, 24);
    run_frame("par_bad_07", 8'h07, 1'b1, 1'b0, 24);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
